// File: rtl/writeback_queue.sv
// Multi-lane writeback stage: registered register-file writes plus an in-order
// commit FIFO drained up to LANES records per cycle, with a retired counter.
module writeback_queue #(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES-1:0]        in_valid,
    input  logic [32*LANES-1:0]     in_inst,
    input  logic [XLEN*LANES-1:0]   in_pc,
    input  logic [XLEN*LANES-1:0]   in_value,
    input  logic [LANES-1:0]        in_wen,
    input  logic [LANES-1:0]        in_jump,
    input  logic [LANES-1:0]        in_skip,
    output logic                    in_ready,
    output logic [LANES-1:0]        rf_wen,
    output logic [5*LANES-1:0]      rf_addr,
    output logic [XLEN*LANES-1:0]   rf_data,
    output logic [LANES-1:0]        commit_valid,
    output logic [32*LANES-1:0]     commit_inst,
    output logic [XLEN*LANES-1:0]   commit_pc,
    output logic [LANES-1:0]        commit_jump,
    output logic [LANES-1:0]        commit_skip,
    output logic [CNT_W*LANES-1:0]  commit_counter,
    input  logic                    commit_ready,
    output logic [CNT_W-1:0]        retired
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] LANES_C = CW'(LANES);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]        inst_mem [DEPTH];
    logic [XLEN-1:0]    pc_mem   [DEPTH];
    logic               jump_mem [DEPTH];
    logic               skip_mem [DEPTH];

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [LANES-1:0]   rf_wen_q, rf_wen_d;
    logic [5*LANES-1:0] rf_addr_q;
    logic [XLEN*LANES-1:0] rf_data_q;

    logic               accept;
    logic [CW-1:0]      enq_n;
    logic [CW-1:0]      pop_n;
    logic [4:0]         rd     [LANES];
    logic [CW-1:0]      offs   [LANES+1];

    assign in_ready = (DEPTH_C - count_q) >= LANES_C;
    assign accept   = in_ready && (|in_valid);

    // offs[i] = number of valid lanes below lane i, i.e. its compacted slot
    assign offs[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PTR_W-1:0] slot_ptr;

            assign rd[gi]       = in_inst[32*gi+7 +: 5];
            assign offs[gi+1]   = offs[gi] + CW'(in_valid[gi]);

            assign slot_ptr     = head_q + PTR_W'(gi);
            assign commit_valid[gi]                 = count_q > CW'(gi);
            assign commit_inst[32*gi +: 32]         = inst_mem[slot_ptr];
            assign commit_pc[XLEN*gi +: XLEN]       = pc_mem[slot_ptr];
            assign commit_jump[gi]                  = jump_mem[slot_ptr];
            assign commit_skip[gi]                  = skip_mem[slot_ptr];
            assign commit_counter[CNT_W*gi +: CNT_W] = retired_q + CNT_W'(gi + 1);
        end
    endgenerate

    assign enq_n = accept ? offs[LANES] : '0;

    always_comb begin
        pop_n = '0;
        if (commit_ready) begin
            pop_n = (count_q < LANES_C) ? count_q : LANES_C;
        end
    end

    assign head_d    = head_q + PTR_W'(pop_n);
    assign tail_d    = tail_q + PTR_W'(enq_n);
    assign count_d   = count_q + enq_n - pop_n;
    assign retired_d = retired_q + CNT_W'(pop_n);

    // A higher lane writing the same rd in the same beat is younger and wins
    always_comb begin
        rf_wen_d = '0;
        for (int i = 0; i < LANES; i++) begin
            rf_wen_d[i] = accept && in_valid[i] && in_wen[i] && (rd[i] != 5'd0);
            for (int j = i + 1; j < LANES; j++) begin
                if (in_valid[j] && in_wen[j] && (rd[j] == rd[i])) begin
                    rf_wen_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            retired_q <= '0;
            rf_wen_q  <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            retired_q <= retired_d;
            rf_wen_q  <= rf_wen_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            rf_addr_q[5*i +: 5]       <= rd[i];
            rf_data_q[XLEN*i +: XLEN] <= in_value[XLEN*i +: XLEN];
        end
    end

    // Storage is not reset: stale entries are unreachable once count is cleared
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (in_valid[i]) begin
                    inst_mem[tail_q + PTR_W'(offs[i])] <= in_inst[32*i +: 32];
                    pc_mem[tail_q + PTR_W'(offs[i])]   <= in_pc[XLEN*i +: XLEN];
                    jump_mem[tail_q + PTR_W'(offs[i])] <= in_jump[i];
                    skip_mem[tail_q + PTR_W'(offs[i])] <= in_skip[i];
                end
            end
        end
    end

    assign rf_wen  = rf_wen_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (LANES=2, DEPTH=8): register writes,
// collisions, compaction, full/wrap, sustained throughput and reset.
module tb_writeback_queue;

    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 64;
    localparam int CNT_W = 64;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [LANES-1:0]        in_valid;
    logic [32*LANES-1:0]     in_inst;
    logic [XLEN*LANES-1:0]   in_pc;
    logic [XLEN*LANES-1:0]   in_value;
    logic [LANES-1:0]        in_wen;
    logic [LANES-1:0]        in_jump;
    logic [LANES-1:0]        in_skip;
    logic                    in_ready;
    logic [LANES-1:0]        rf_wen;
    logic [5*LANES-1:0]      rf_addr;
    logic [XLEN*LANES-1:0]   rf_data;
    logic [LANES-1:0]        commit_valid;
    logic [32*LANES-1:0]     commit_inst;
    logic [XLEN*LANES-1:0]   commit_pc;
    logic [LANES-1:0]        commit_jump;
    logic [LANES-1:0]        commit_skip;
    logic [CNT_W*LANES-1:0]  commit_counter;
    logic                    commit_ready;
    logic [CNT_W-1:0]        retired;

    int checks   = 0;
    int failures = 0;

    writeback_queue #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .in_value       (in_value),
        .in_wen         (in_wen),
        .in_jump        (in_jump),
        .in_skip        (in_skip),
        .in_ready       (in_ready),
        .rf_wen         (rf_wen),
        .rf_addr        (rf_addr),
        .rf_data        (rf_data),
        .commit_valid   (commit_valid),
        .commit_inst    (commit_inst),
        .commit_pc      (commit_pc),
        .commit_jump    (commit_jump),
        .commit_skip    (commit_skip),
        .commit_counter (commit_counter),
        .commit_ready   (commit_ready),
        .retired        (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        in_valid = '0;
        in_inst  = '0;
        in_pc    = '0;
        in_value = '0;
        in_wen   = '0;
        in_jump  = '0;
        in_skip  = '0;
    endtask

    task automatic put(input int l, input logic [63:0] pc, input logic [4:0] rd,
                       input logic [63:0] val, input logic wen, input logic jmp);
        in_valid[l]           = 1'b1;
        in_inst[32*l +: 32]   = {20'h0, rd, 7'h13};
        in_pc[64*l +: 64]     = pc;
        in_value[64*l +: 64]  = val;
        in_wen[l]             = wen;
        in_jump[l]            = jmp;
        in_skip[l]            = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        commit_ready = 1'b0;
        clear_in();

        // Reset and idle
        tick(); tick();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_cvalid", 128'(commit_valid), 128'd0);
        chk("rst_rf_wen", 128'(rf_wen), 128'd0);
        chk("rst_retired", 128'(retired), 128'd0);
        reset = 1'b1;
        tick();
        $display("txn reset_idle in_ready=%0d", in_ready);

        // Two lanes rd5/rd6
        put(0, 64'h1000, 5'd5, 64'h11, 1'b1, 1'b0);
        put(1, 64'h1004, 5'd6, 64'h22, 1'b1, 1'b0);
        tick();
        clear_in();
        chk("pair_rf_wen", 128'(rf_wen), 128'b11);
        chk("pair_rf_addr", 128'(rf_addr), 128'({5'd6, 5'd5}));
        chk("pair_rf_data", 128'(rf_data), {64'h22, 64'h11});
        chk("pair_cvalid", 128'(commit_valid), 128'b11);
        chk("pair_cpc", 128'(commit_pc), {64'h1004, 64'h1000});
        chk("pair_ccnt", 128'(commit_counter), {64'd2, 64'd1});
        chk("pair_cinst0", 128'(commit_inst[11:7]), 128'd5);
        commit_ready = 1'b1;
        tick();
        commit_ready = 1'b0;
        chk("pair_retired", 128'(retired), 128'd2);
        chk("pair_empty", 128'(commit_valid), 128'd0);
        chk("pair_rf_idle", 128'(rf_wen), 128'd0);
        $display("txn pair retired=%0d", retired);

        // Same-rd collision, lane 1 wins
        put(0, 64'h2000, 5'd7, 64'hA, 1'b1, 1'b0);
        put(1, 64'h2004, 5'd7, 64'hB, 1'b1, 1'b1);
        tick();
        clear_in();
        chk("coll_rf_wen", 128'(rf_wen), 128'b10);
        chk("coll_rf_data1", 128'(rf_data[127:64]), 128'hB);
        chk("coll_rf_addr1", 128'(rf_addr[9:5]), 128'd7);
        chk("coll_ccnt0", 128'(commit_counter[63:0]), 128'd3);
        chk("coll_jump", 128'(commit_jump), 128'b10);
        chk("coll_skip", 128'(commit_skip), 128'b00);
        $display("txn collision rf_wen=%b", rf_wen);

        // rd = x0 write suppressed but still committed
        put(0, 64'h3000, 5'd0, 64'h55, 1'b1, 1'b0);
        tick();
        clear_in();
        chk("x0_rf_wen", 128'(rf_wen), 128'd0);
        chk("x0_cpc0", 128'(commit_pc[63:0]), 128'h2000);
        commit_ready = 1'b1;
        tick();
        chk("x0_retired", 128'(retired), 128'd4);
        chk("x0_cvalid", 128'(commit_valid), 128'b01);
        chk("x0_cpc0b", 128'(commit_pc[63:0]), 128'h3000);
        chk("x0_ccnt0", 128'(commit_counter[63:0]), 128'd5);
        tick();
        chk("x0_retired2", 128'(retired), 128'd5);
        chk("x0_drained", 128'(commit_valid), 128'd0);
        tick();
        chk("empty_pop_retired", 128'(retired), 128'd5);
        commit_ready = 1'b0;
        $display("txn x0 retired=%0d", retired);

        // Compaction of single-lane beats
        put(1, 64'h100, 5'd1, 64'h1, 1'b0, 1'b0);
        tick();
        clear_in();
        chk("cmp_rf_wen", 128'(rf_wen), 128'd0);
        chk("cmp_cvalid1", 128'(commit_valid), 128'b01);
        put(0, 64'h104, 5'd2, 64'h2, 1'b0, 1'b0);
        tick();
        clear_in();
        chk("cmp_cvalid", 128'(commit_valid), 128'b11);
        chk("cmp_cpc", 128'(commit_pc), {64'h104, 64'h100});
        commit_ready = 1'b1;
        tick();
        commit_ready = 1'b0;
        chk("cmp_retired", 128'(retired), 128'd7);
        $display("txn compaction retired=%0d", retired);

        // Fill to DEPTH, then drain across the pointer wrap
        for (int k = 0; k < 4; k++) begin
            chk("fill_ready", 128'(in_ready), 128'd1);
            put(0, 64'h400 + 64'(8*k), 5'd3, 64'h0, 1'b1, 1'b0);
            put(1, 64'h404 + 64'(8*k), 5'd4, 64'h0, 1'b1, 1'b0);
            tick();
        end
        chk("full_ready", 128'(in_ready), 128'd0);
        put(0, 64'h500, 5'd3, 64'h0, 1'b1, 1'b0);
        put(1, 64'h504, 5'd4, 64'h0, 1'b1, 1'b0);
        tick();
        chk("full_hold_ready", 128'(in_ready), 128'd0);
        chk("full_hold_rf", 128'(rf_wen), 128'd0);
        chk("full_hold_cpc", 128'(commit_pc), {64'h404, 64'h400});
        clear_in();
        commit_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("drain_ready", 128'(in_ready), 128'd1);
            chk("drain_cpc", 128'(commit_pc), {64'h404 + 64'(8*k), 64'h400 + 64'(8*k)});
        end
        tick();
        chk("drain_empty", 128'(commit_valid), 128'd0);
        chk("drain_retired", 128'(retired), 128'd15);
        $display("txn full_drain retired=%0d", retired);

        // Sustained 2-in / 2-out
        for (int k = 0; k < 20; k++) begin
            put(0, 64'h8000 + 64'(8*k), 5'd8, 64'h0, 1'b1, 1'b0);
            put(1, 64'h8004 + 64'(8*k), 5'd9, 64'h0, 1'b1, 1'b0);
            tick();
            chk("sus_ready", 128'(in_ready), 128'd1);
            chk("sus_retired", 128'(retired), 128'(15 + 2*k));
            chk("sus_ccnt", 128'(commit_counter), {64'(17 + 2*k), 64'(16 + 2*k)});
            chk("sus_cpc0", 128'(commit_pc[63:0]), 128'(64'h8000 + 64'(8*k)));
        end
        clear_in();
        tick();
        chk("sus_final_retired", 128'(retired), 128'd55);
        chk("sus_final_empty", 128'(commit_valid), 128'd0);
        commit_ready = 1'b0;
        $display("txn sustained retired=%0d", retired);

        // Reset mid-stream with 3 entries queued
        put(0, 64'h9000, 5'd9, 64'h1, 1'b1, 1'b0);
        put(1, 64'h9004, 5'd10, 64'h2, 1'b1, 1'b0);
        tick();
        clear_in();
        put(0, 64'h9008, 5'd11, 64'h3, 1'b1, 1'b0);
        tick();
        chk("pre_rst_rf_wen", 128'(rf_wen), 128'b01);
        chk("pre_rst_cvalid", 128'(commit_valid), 128'b11);
        reset = 1'b0;
        commit_ready = 1'b1;
        put(0, 64'hA000, 5'd12, 64'h4, 1'b1, 1'b0);
        put(1, 64'hA004, 5'd13, 64'h5, 1'b1, 1'b0);
        tick();
        chk("mid_rst_cvalid", 128'(commit_valid), 128'd0);
        chk("mid_rst_rf_wen", 128'(rf_wen), 128'd0);
        chk("mid_rst_retired", 128'(retired), 128'd0);
        chk("mid_rst_ready", 128'(in_ready), 128'd1);
        reset = 1'b1;
        commit_ready = 1'b0;
        clear_in();
        tick();
        chk("post_rst_cvalid", 128'(commit_valid), 128'd0);
        chk("post_rst_retired", 128'(retired), 128'd0);
        $display("txn mid_reset retired=%0d", retired);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
